// File: rtl/vector_op_arbiter.sv
// vector_op_arbiter
// Round-robin arbiter in front of one shared 8-bit vector datapath
// (slice, reverse, reduce, popcount, invert).
// Each accepted request makes one pass IDLE -> GRANT -> EXEC -> DONE. The
// result is held on a valid/ready channel and tagged with the requester index.
// Optional build macro VOP_TIMEOUT_EN adds a stall timeout (TIMEOUT
// parameter) that drops a result after TIMEOUT back-pressured cycles. When
// the timeout fires, the sticky drop_flag output is set.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no operation in flight; pick next requester from ptr upward
// GRANT | req_ready[gnt] pulses; operand, opcode and ID are latched
// EXEC  | datapath result registered into res_data
// DONE  | res_valid held until res_ready (or timeout when enabled)

module vector_op_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
`ifdef VOP_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 15
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ*3-1:0] req_op,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [7:0]           res_data,
   output logic [2:0]           res_op,
   output logic [ID_W-1:0]      res_id,
   output logic                 busy
`ifdef VOP_TIMEOUT_EN
   ,
   output logic                 drop_flag
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      EXEC  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] gnt;
   logic [ID_W-1:0] sel_idx;
   logic [ID_W-1:0] cand;
   logic            sel_found;
   logic [7:0]      opnd;
   logic [2:0]      opc;
   logic [7:0]      data_arr [NUM_REQ];
   logic [2:0]      op_arr   [NUM_REQ];

`ifdef VOP_TIMEOUT_EN
   // Counter only needs to reach TIMEOUT-1; 4 bits cover the default.
   localparam int TO_W = (TIMEOUT < 16) ? 4 : 8;
   logic [TO_W-1:0] stall_cnt;
`endif

   // Index arithmetic modulo NUM_REQ, kept in ID_W bits so the
   // NUM_REQ-1 -> 0 wrap works for non-power-of-two requester counts.
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a,
                                                input int k);
      int s;
      s = int'(a) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   // Shared datapath, evaluated on the latched operand during EXEC.
   function automatic logic [7:0] vop_compute(input logic [2:0] op,
                                              input logic [7:0] d);
      logic [7:0] r;
      logic [3:0] cnt;
      r   = '0;
      cnt = '0;
      case (op)
         3'd0: r = d;
         3'd1: for (int i = 0; i < 8; i++) r[i] = d[7-i];
         3'd2: r = {7'b0, ^d};
         3'd3: r = {4'b0, d[3:0]};
         3'd4: r = {4'b0, d[7:4]};
         3'd5: r = {d[3:0], d[7:4]};
         3'd6: begin
            for (int i = 0; i < 8; i++) cnt = cnt + {3'b0, d[i]};
            r = {4'b0, cnt};
         end
         default: r = ~d;
      endcase
      return r;
   endfunction

   // Unpack the flat requester buses so the winner can be indexed directly.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[8*i +: 8];
      assign op_arr[i]   = req_op[3*i +: 3];
   end

   // Round-robin pick: first valid requester scanning upward from ptr.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrap_add(ptr, k);
         if (!sel_found && req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Sequencer FSM; every output is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         opnd      <= '0;
         opc       <= '0;
         req_ready <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_op    <= '0;
         res_id    <= '0;
         busy      <= 1'b0;
`ifdef VOP_TIMEOUT_EN
         stall_cnt <= '0;
         drop_flag <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  gnt       <= sel_idx;
                  req_ready <= NUM_REQ'(1) << sel_idx;
                  busy      <= 1'b1;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               req_ready <= '0;
               opnd      <= data_arr[gnt];
               opc       <= op_arr[gnt];
               res_id    <= gnt;
               state     <= EXEC;
            end
            EXEC: begin
               res_data  <= vop_compute(opc, opnd);
               res_op    <= opc;
               res_valid <= 1'b1;
`ifdef VOP_TIMEOUT_EN
               stall_cnt <= '0;
`endif
               state     <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  ptr       <= wrap_add(gnt, 1);
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
`ifdef VOP_TIMEOUT_EN
               // Drop on the TIMEOUT-th stalled cycle, as if handshaken.
               else if (stall_cnt == TO_W'(TIMEOUT - 1)) begin
                  res_valid <= 1'b0;
                  ptr       <= wrap_add(gnt, 1);
                  busy      <= 1'b0;
                  drop_flag <= 1'b1;
                  state     <= IDLE;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_op_arbiter.sv
// Self-checking bench for vector_op_arbiter: scoreboard of expected results,
// filled at each grant and drained at each output handshake.
// Optional build macro VOP_TIMEOUT_EN switches the stall test to the drop test.

module tb_vector_op_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*8-1:0] req_data;
   logic [N*3-1:0] req_op;
   logic [N-1:0]   req_ready;
   logic           res_valid;
   logic           res_ready;
   logic [7:0]     res_data;
   logic [2:0]     res_op;
   logic [1:0]     res_id;
   logic           busy;
`ifdef VOP_TIMEOUT_EN
   logic           drop_flag;
`endif

   logic [7:0] tdata [N];
   logic [2:0] top   [N];
   int         rem   [N];

   typedef struct packed {
      logic [1:0] id;
      logic [2:0] op;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   int         glog[$];
   int         gtime[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   logic [1:0] mptr;
   logic       gnt_seen;

   vector_op_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_op    (req_op),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_op    (res_op),
      .res_id    (res_id),
      .busy      (busy)
`ifdef VOP_TIMEOUT_EN
      ,
      .drop_flag (drop_flag)
`endif
   );

   always #5 clk = ~clk;

   always_comb begin
      req_data = '0;
      req_op   = '0;
      for (int i = 0; i < N; i++) begin
         req_data[i*8 +: 8] = tdata[i];
         req_op[i*3 +: 3]   = top[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_op(input logic [2:0] op,
                                         input logic [7:0] d);
      logic [7:0] r;
      r = '0;
      case (op)
         3'd0: r = d;
         3'd1: for (int i = 0; i < 8; i++) r[i] = d[7-i];
         3'd2: r = {7'd0, ^d};
         3'd3: r = {4'd0, d[3:0]};
         3'd4: r = {4'd0, d[7:4]};
         3'd5: r = {d[3:0], d[7:4]};
         3'd6: r = 8'($countones(d));
         default: r = ~d;
      endcase
      return r;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input logic [1:0] p);
      logic [1:0] j;
      for (int k = 0; k < N; k++) begin
         j = p + 2'(k);
         if (v[j]) return int'(j);
      end
      return -1;
   endfunction

   // One clock: capture the handshake condition for the coming edge, then
   // at the falling edge score grants and completed results.
   task automatic tick();
      logic       hs;
      logic       rst_c;
      exp_t       got;
      exp_t       e;
      int         g;
      logic [1:0] gi;
      hs       = res_valid && res_ready;
      rst_c    = rst;
      got.id   = res_id;
      got.op   = res_op;
      got.data = res_data;
      @(negedge clk);
      cyc++;
      gnt_seen = 1'b0;
      if (rst_c) begin
         sb.delete();
         mptr = 2'd0;
      end else begin
         if (hs) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               check("res_id",   32'(got.id),   32'(e.id));
               check("res_op",   32'(got.op),   32'(e.op));
               check("res_data", 32'(got.data), 32'(e.data));
               mptr = e.id + 2'd1;
            end
         end
         if (req_ready != '0) begin
            g = rr_pick(req_valid, mptr);
            check("grant", 32'(req_ready), 32'(1) << g);
            gnt_seen = 1'b1;
            if (g >= 0) begin
               gi     = 2'(g);
               e.id   = gi;
               e.op   = top[gi];
               e.data = ref_op(top[gi], tdata[gi]);
               sb.push_back(e);
               glog.push_back(g);
               gtime.push_back(cyc);
               rem[gi] = rem[gi] - 1;
               if (rem[gi] <= 0) req_valid[gi] = 1'b0;
            end
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy || res_valid || req_valid != '0 || sb.size() != 0) &&
             n < budget) begin
         tick();
         n++;
      end
      check("idle_budget", 32'(n < budget), 32'(1));
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      req_valid = '0;
      res_ready = 1'b0;
      mptr      = 2'd0;
      gnt_seen  = 1'b0;
      for (int i = 0; i < N; i++) begin
         tdata[i] = '0;
         top[i]   = '0;
         rem[i]   = 0;
      end

      // Reset state
      tick();
      tick();
      check("rst_req_ready", 32'(req_ready), 32'(0));
      check("rst_res_valid", 32'(res_valid), 32'(0));
      check("rst_res_data",  32'(res_data),  32'(0));
      check("rst_res_op",    32'(res_op),    32'(0));
      check("rst_res_id",    32'(res_id),    32'(0));
      check("rst_busy",      32'(busy),      32'(0));
`ifdef VOP_TIMEOUT_EN
      check("rst_drop_flag", 32'(drop_flag), 32'(0));
`endif
      rst       = 1'b0;
      res_ready = 1'b1;

      // Single requester 2, minimum latency
      tdata[2] = 8'hB4; top[2] = 3'd1; rem[2] = 1; req_valid[2] = 1'b1;
      tick();
      check("lat_req_ready", 32'(req_ready), 32'(4'b0100));
      check("lat_busy",      32'(busy),      32'(1));
      tick();
      check("lat_valid_early", 32'(res_valid), 32'(0));
      tick();
      check("lat_valid",    32'(res_valid), 32'(1));
      check("lat_res_data", 32'(res_data),  32'(8'h2D));
      check("lat_res_id",   32'(res_id),    32'(2));
      wait_idle(20);

      // All four valid from ptr 0: order 0,1,2,3,0
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < N; i++) tdata[i] = 8'hF0;
      top[0] = 3'd6; top[1] = 3'd2; top[2] = 3'd5; top[3] = 3'd7;
      rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
      glog.delete();
      req_valid = 4'b1111;
      wait_idle(60);
      check("rr_count", 32'(glog.size()), 32'(5));
      if (glog.size() == 5) begin
         check("rr_order0", 32'(glog[0]), 32'(0));
         check("rr_order1", 32'(glog[1]), 32'(1));
         check("rr_order2", 32'(glog[2]), 32'(2));
         check("rr_order3", 32'(glog[3]), 32'(3));
         check("rr_wrap",   32'(glog[4]), 32'(0));
      end

      // Every opcode on requester 1 with random operands
      for (int op = 0; op < 8; op++) begin
         tdata[1] = 8'($urandom);
         top[1]   = 3'(op);
         rem[1]   = 1;
         req_valid[1] = 1'b1;
         wait_idle(20);
      end

      // Lone requester re-granted back-to-back at one op per 4 cycles
      glog.delete(); gtime.delete();
      tdata[1] = 8'h96; top[1] = 3'd6; rem[1] = 3; req_valid[1] = 1'b1;
      wait_idle(40);
      check("b2b_count", 32'(glog.size()), 32'(3));
      if (gtime.size() == 3) begin
         check("b2b_gap0", 32'(gtime[1] - gtime[0]), 32'(4));
         check("b2b_gap1", 32'(gtime[2] - gtime[1]), 32'(4));
      end

      // Back-pressure in DONE; requester 0 waits meanwhile
      res_ready = 1'b0;
      tdata[3] = 8'h5A; top[3] = 3'd7; rem[3] = 1; req_valid[3] = 1'b1;
      n = 0;
      while (!res_valid && n < 20) begin tick(); n++; end
      check("stall_reach_done", 32'(n < 20), 32'(1));
      tdata[0] = 8'h3C; top[0] = 3'd0; rem[0] = 1; req_valid[0] = 1'b1;
`ifndef VOP_TIMEOUT_EN
      for (int i = 0; i < 20; i++) begin
         tick();
         check("stall_valid",     32'(res_valid), 32'(1));
         check("stall_data",      32'(res_data),  32'(8'hA5));
         check("stall_no_grant",  32'(req_ready), 32'(0));
      end
      res_ready = 1'b1;
      wait_idle(30);
`else
      for (int i = 0; i < 14; i++) begin
         tick();
         check("to_valid_held", 32'(res_valid), 32'(1));
         check("to_no_grant",   32'(req_ready), 32'(0));
      end
      tick();
      check("to_valid_drop", 32'(res_valid), 32'(0));
      check("to_drop_flag",  32'(drop_flag), 32'(1));
      if (sb.size() > 0) void'(sb.pop_front());
      mptr = 2'd0;
      res_ready = 1'b1;
      wait_idle(30);
      check("to_drop_sticky", 32'(drop_flag), 32'(1));
`endif

      // Reset during EXEC: in-flight result lost, ptr back to 0
      res_ready = 1'b1;
      tdata[0] = 8'h81; top[0] = 3'd3; rem[0] = 1;
      tdata[2] = 8'hC3; top[2] = 3'd4; rem[2] = 2;
      glog.delete();
      req_valid = 4'b0101;
      n = 0;
      while (!gnt_seen && n < 10) begin tick(); n++; end
      check("pre_rst_grant", 32'(n < 10), 32'(1));
      if (glog.size() > 0) check("pre_rst_gnt_id", 32'(glog[0]), 32'(2));
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("mid_rst_valid",     32'(res_valid), 32'(0));
      check("mid_rst_busy",      32'(busy),      32'(0));
      check("mid_rst_req_ready", 32'(req_ready), 32'(0));
`ifdef VOP_TIMEOUT_EN
      check("mid_rst_drop_flag", 32'(drop_flag), 32'(0));
`endif
      glog.delete();
      wait_idle(40);
      check("post_rst_count", 32'(glog.size()), 32'(2));
      if (glog.size() == 2) begin
         check("post_rst_first",  32'(glog[0]), 32'(0));
         check("post_rst_second", 32'(glog[1]), 32'(2));
      end
      check("sb_drained", 32'(sb.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vector_op_arbiter.md
Name: vector_op_arbiter

Overview:
- Shares one 8-bit vector-manipulation datapath (bit slicing, reversal, reduction) among NUM_REQ requesters.
- Arbitrates round-robin, latches the winning operand and opcode, and computes the result in a registered stage.
- Presents the result on a valid/ready output channel tagged with the requester ID.
- Sits between the byte-producing front-end blocks and the vector result consumers in the vector_V subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_data  input  NUM_REQ*8  operand bytes; requester i occupies bits [8i+7:8i].
- req_op  input  NUM_REQ*3  opcodes; requester i occupies bits [3i+2:3i].
- req_ready  output  NUM_REQ  one-hot grant/accept strobe.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer ready.
- res_data  output  8  result byte.
- res_op  output  3  opcode of the result.
- res_id  output  ID_W  index of the requester that owns the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs go to 0.
  - State goes to IDLE.
  - Round-robin pointer goes to 0.
  - Reset mid-operation discards any in-flight result with no output handshake.
- State machine: IDLE -> GRANT -> EXEC -> DONE -> IDLE.
- IDLE:
  - If any req_valid is high, select the first valid index scanning from ptr upward, wrapping modulo NUM_REQ.
  - Register the selection as gnt and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - req_ready[gnt] is high for exactly this cycle; all other req_ready bits stay 0.
  - Latch req_data/req_op of gnt into the operand registers; latch gnt into the ID register.
  - Go to EXEC.
  - Requesters must hold valid, data and op stable from assertion until their req_ready.
  - Valid dropping before GRANT is a protocol violation and is not checked.
- EXEC: compute the result from the latched operand d, register it into res_data, go to DONE. Opcodes:
  - 0: d (pass-through).
  - 1: bit-reverse; res[i] = d[7-i].
  - 2: {7'b0, ^d} (XOR reduction).
  - 3: {4'b0, d[3:0]}.
  - 4: {4'b0, d[7:4]}.
  - 5: {d[3:0], d[7:4]} (nibble swap).
  - 6: population count, zero-extended, range 0..8.
  - 7: ~d.
- DONE:
  - res_valid = 1; res_data, res_op and res_id are stable while res_valid is high.
  - When res_valid and res_ready are both high at a clk edge: clear res_valid, set ptr = (gnt+1) mod NUM_REQ, go to IDLE.
  - Backpressure of any length is allowed; no new grant is issued while in DONE.
- Timing:
  - Minimum latency: req_valid seen in IDLE -> req_ready 1 cycle later -> res_valid 2 cycles after req_ready.
  - Peak throughput: one operation per 4 cycles with res_ready tied high.
- Simultaneous requests: strict round-robin from ptr. After requester k is served it has the lowest priority.
- Wrap-around: ptr goes from NUM_REQ-1 to 0.
- A requester that is the only valid requester is re-granted back-to-back.
- res_ready held high while not in DONE has no effect.

Optional Feature:
- Macro: VOP_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 15) and output drop_flag (1 bit, sticky).
  - In DONE, a 4..8-bit counter increments on each cycle with res_valid high and res_ready low.
  - When the count reaches TIMEOUT, the result is dropped: res_valid clears, ptr advances as on a normal handshake, state returns to IDLE, drop_flag sets.
  - drop_flag clears only on rst.
  - The counter clears on entry to DONE.
- When undefined: no counter and no drop_flag port; DONE waits indefinitely.

Test Plan:
- Reset with rst=1 for 2 cycles, all req_valid=0 -> every output is 0, busy=0.
- Requester 2 only: data 8'hB4, op 1 -> req_ready=4'b0100 one cycle later; res_valid 2 cycles after that with res_data=8'h2D, res_id=2, res_op=1.
- All four requesters valid, ops 6/2/5/7 on data 8'hF0 each, res_ready=1 -> grant order 0,1,2,3,0; results 8'h04, 8'h00, 8'h0F, 8'h0F; ptr wraps to 0.
- res_ready=0 for 20 cycles in DONE with the macro undefined -> res_valid and res_data held, no req_ready pulses; res_ready=1 -> handshake completes and IDLE resumes.
- Assert rst during EXEC -> next cycle res_valid=0, busy=0, ptr=0; the pending request is re-granted from requester 0 priority.
- With VOP_TIMEOUT_EN and TIMEOUT=15, hold res_ready=0 -> res_valid drops after 15 stall cycles, drop_flag=1 and stays set until rst.
